// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI register/FIFO link: opcodes, command bytes
// and the per-op byte sequence tables used by both ends of the link.
package spi_link_pkg;

  typedef enum logic [1:0] {
    OP_REG_WR  = 2'd0,
    OP_REG_RD  = 2'd1,
    OP_FIFO_RD = 2'd2,
    OP_FIFO_WR = 2'd3
  } op_t;

  localparam logic [7:0] CMD_REG     = 8'h89;
  localparam logic [7:0] CMD_FIFO_RD = 8'h8A;
  localparam logic [7:0] CMD_FIFO_WR = 8'h8B;

  // Out-of-range index returned by cap_idx for ops that capture nothing.
  localparam logic [2:0] NO_CAP = 3'd7;

  function automatic logic [2:0] seq_len(op_t op);
    case (op)
      OP_REG_WR, OP_REG_RD: return 3'd4;
      OP_FIFO_RD:           return 3'd3;
      default:              return 3'd2;
    endcase
  endfunction

  function automatic logic [7:0] seq_byte(op_t op, logic [1:0] idx,
                                          logic [6:0] addr, logic [7:0] data);
    logic [7:0] b;
    b = 8'h00;
    case (op)
      OP_REG_WR: begin
        case (idx)
          2'd0:    b = CMD_REG;
          2'd1:    b = {1'b1, addr};
          2'd2:    b = data;
          default: b = 8'h00;
        endcase
      end
      OP_REG_RD: begin
        case (idx)
          2'd0:    b = CMD_REG;
          2'd1:    b = {1'b0, addr};
          default: b = 8'h00;
        endcase
      end
      OP_FIFO_RD: b = (idx == 2'd0) ? CMD_FIFO_RD : 8'h00;
      default:    b = (idx == 2'd0) ? CMD_FIFO_WR : data;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] cap_idx(op_t op);
    case (op)
      OP_REG_RD:  return 3'd3;
      OP_FIFO_RD: return 3'd2;
      default:    return NO_CAP;
    endcase
  endfunction

endpackage

// File: rtl/spi_link_host.sv
// Host-side link initiator: turns one command request into its byte sequence
// on a full-duplex SPI byte engine and returns the read byte or a timeout.
module spi_link_host
  import spi_link_pkg::*;
#(
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [1:0] i_req_op,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid
);

  localparam int MAXC  = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE} state_t;

  state_t           r_state;
  op_t              r_op;
  logic [6:0]       r_addr;
  logic [7:0]       r_data;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;   // gap count in S_GAP, timeout count in S_WAIT
  logic [7:0]       r_rdata;
  logic             r_err;

  state_t w_nxt;
  logic   w_last;
  logic   w_cnt_sat;

  always_comb begin
    w_nxt       = r_state;
    w_last      = ({1'b0, r_idx} == (seq_len(r_op) - 3'd1));
    w_cnt_sat   = &r_cnt;
    o_req_ready = (r_state == S_IDLE) && !i_rst;
    o_tx_valid  = (r_state == S_SEND);
    o_tx_byte   = 8'h00;
    o_rsp_valid = (r_state == S_DONE);
    o_rsp_err   = (r_state == S_DONE) && r_err;
    o_rsp_data  = 8'h00;
    if (r_state == S_SEND) o_tx_byte = seq_byte(r_op, r_idx, r_addr, r_data);
    if (r_state == S_DONE && !r_err) o_rsp_data = r_rdata;
    case (r_state)
      S_IDLE: if (i_req_valid) w_nxt = S_SEND;
      S_SEND: if (i_tx_ready) w_nxt = S_WAIT;
      S_WAIT: begin
        // A strobe arriving in the final counted cycle still wins over the timeout.
        if (i_rx_valid) begin
          if (w_last)                w_nxt = S_DONE;
          else if (GAP_CYCLES == 0)  w_nxt = S_SEND;
          else                       w_nxt = S_GAP;
        end else if (r_cnt == TO_LAST) begin
          w_nxt = S_DONE;
        end
      end
      S_GAP:  if (r_cnt == GAP_LAST) w_nxt = S_SEND;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_REG_WR;
      r_addr  <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_op    <= op_t'(i_req_op);
          r_addr  <= i_req_addr;
          r_data  <= i_req_data;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        S_SEND: if (i_tx_ready) r_cnt <= '0;
        S_WAIT: begin
          if (i_rx_valid) begin
            if ({1'b0, r_idx} == cap_idx(r_op)) r_rdata <= i_rx_byte;
            if (!w_last) r_idx <= r_idx + 2'd1;
            r_cnt <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_err <= 1'b1;
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: if (!w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_link_host.sv
// Randomized scoreboard bench for spi_link_host with a behavioural SPI byte
// engine; directed cases cover stalls, timeout and mid-transaction reset.
module tb_spi_link_host;

  localparam int GAP = 8;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic       o_req_ready, o_rsp_valid, o_rsp_err, o_tx_valid;
  logic [7:0] o_rsp_data, o_tx_byte;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  spi_link_host #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_op(req_op), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid), .i_tx_ready(tx_ready),
    .i_rx_byte(rx_byte), .i_rx_valid(rx_valid)
  );

  typedef struct packed { logic e; logic [7:0] d; } rsp_t;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];
  logic [7:0] rx_q[$];
  int n_chk = 0, n_fail = 0;
  int hs_total = 0, drop_hs = -1, stall_hs = -1;
  int rx_seen = 0, rsp_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", nm, act, cyc);
  endtask

  // SPI byte engine: random accept delay, random rx latency, optional stall/drop
  initial begin : spi_model
    int cd, wl;
    bit pend, started;
    cd = 0; wl = 0; pend = 0; started = 0;
    forever begin
      @(posedge clk); #2;
      rx_valid = 1'b0;
      if (rst) begin
        pend = 0; started = 0; tx_ready = 1'b0;
      end else begin
        if (tx_ready) begin
          tx_ready = 1'b0;
          hs_total++;
          started = 0;
          if (hs_total != drop_hs) begin pend = 1; cd = $urandom_range(0, 4); end
        end
        if (pend) begin
          if (cd == 0) begin
            rx_valid = 1'b1;
            rx_byte  = (rx_q.size() != 0) ? rx_q.pop_front() : 8'($urandom);
            pend = 0;
          end else cd--;
        end
        if (o_tx_valid) begin
          if (!started) begin
            started = 1;
            wl = (hs_total + 1 == stall_hs) ? 5 : $urandom_range(0, 1);
          end
          if (wl == 0) tx_ready = 1'b1;
          else wl--;
        end
      end
    end
  end

  // Monitor / scoreboard
  int   last_rx = -1, acc_cyc = -1, hs_cyc = -1;
  bit   busy = 0, prev_tv = 0, prev_hs = 0;
  logic [7:0] prev_b = 8'h00;
  rsp_t mr;

  always @(negedge clk) begin
    if (rst) begin
      busy = 0; last_rx = -1; acc_cyc = -1; prev_tv = 0; prev_hs = 0;
    end else begin
      if (busy) chk("req_ready_busy", o_req_ready, 0);
      if (o_tx_valid && prev_tv && !prev_hs) chk("tx_byte_stable", o_tx_byte, prev_b);
      if (o_tx_valid && !prev_tv) begin
        if (acc_cyc >= 0) begin chk("accept_to_tx", cyc - acc_cyc, 1); acc_cyc = -1; end
        else if (last_rx >= 0) chk("gap_len", cyc - last_rx, GAP + 1);
      end
      if (o_tx_valid && tx_ready) begin
        hs_cyc = cyc + 1;
        if (exp_tx.size() == 0) fail_now("tx_unexpected", o_tx_byte);
        else chk("tx_byte", o_tx_byte, exp_tx.pop_front());
      end
      if (rx_valid) begin last_rx = cyc; rx_seen++; end
      if (o_rsp_valid) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) fail_now("rsp_unexpected", {o_rsp_err, o_rsp_data});
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_data", o_rsp_data, mr.d);
          chk("rsp_err", o_rsp_err, mr.e);
          if (mr.e) chk("timeout_latency", cyc - hs_cyc, TO);
          else      chk("rx_to_rsp", cyc - last_rx, 1);
        end
        busy = 0; last_rx = -1;
      end else begin
        chk("rsp_idle_zero", {o_rsp_err, o_rsp_data}, 0);
      end
      if (req_valid && o_req_ready) begin busy = 1; acc_cyc = cyc; end
      prev_tv = o_tx_valid;
      prev_hs = o_tx_valid && tx_ready;
      prev_b  = o_tx_byte;
    end
  end

  // mode 0: normal, 1: rx withheld after byte 1 (timeout), 2: reset after byte 0
  task automatic issue(input int op, input logic [6:0] a, input logic [7:0] d,
                       input int mode, input logic [31:0] rxw, input bit rx_given);
    logic [7:0] seq[$];
    logic [7:0] rxb;
    rsp_t r;
    int n, base, k;
    case (op)
      0: begin seq.push_back(8'h89); seq.push_back({1'b1, a}); seq.push_back(d); seq.push_back(8'h00); end
      1: begin seq.push_back(8'h89); seq.push_back({1'b0, a}); seq.push_back(8'h00); seq.push_back(8'h00); end
      2: begin seq.push_back(8'h8A); seq.push_back(8'h00); seq.push_back(8'h00); end
      default: begin seq.push_back(8'h8B); seq.push_back(d); end
    endcase
    n = (mode == 0) ? seq.size() : ((mode == 1) ? 2 : 1);
    r.d = 8'h00;
    r.e = (mode == 1);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(seq[i]);
      rxb = rx_given ? rxw[8*i +: 8] : 8'($urandom);
      if (!(mode == 1 && i == 1)) rx_q.push_back(rxb);
      if (mode == 0 && ((op == 1 && i == 3) || (op == 2 && i == 2))) r.d = rxb;
    end
    if (mode == 1) drop_hs = hs_total + 2;
    if (mode != 2) exp_rsp.push_back(r);
    base = rsp_seen;
    k = 0;
    do begin @(posedge clk); #2; k++; end while (!o_req_ready && k < 200);
    if (!o_req_ready) fail_now("req_ready_wait", 0);
    req_valid = 1'b1; req_op = 2'(op); req_addr = a; req_data = d;
    @(posedge clk); #2;
    req_valid = 1'b0;
    if (mode != 2) begin
      k = 0;
      while (rsp_seen == base && k < 400) begin @(negedge clk); k++; end
      if (rsp_seen == base) fail_now("rsp_wait_expired", op);
    end
  endtask

  initial begin : driver
    int base_rx, base_rsp, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_byte", o_tx_byte, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", o_req_ready, 1);

    issue(0, 7'h24, 8'h00, 0, 0, 0);
    issue(1, 7'h24, 8'h00, 0, 32'h5A33_2211, 1);
    issue(3, 7'h00, 8'hAB, 0, 0, 0);
    issue(3, 7'h00, 8'hCD, 0, 0, 0);
    stall_hs = hs_total + 2;
    issue(2, 7'h00, 8'h00, 0, 32'h00CD_0000, 1);
    stall_hs = -1;
    issue(1, 7'h11, 8'h00, 1, 0, 0);
    issue(1, 7'h11, 8'h00, 0, 32'hC3B2_A190, 1);

    for (int t = 0; t < 30; t++)
      issue($urandom_range(0, 3), 7'($urandom), 8'($urandom), 0, 0, 0);

    // Reset in the inter-byte gap of a REG_WR
    base_rx = rx_seen;
    base_rsp = rsp_seen;
    issue(0, 7'h24, 8'h5A, 2, 0, 0);
    k = 0;
    while (rx_seen == base_rx && k < 100) begin @(negedge clk); k++; end
    if (rx_seen == base_rx) fail_now("rx_wait_expired", 0);
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", o_req_ready, 0);
    @(negedge clk);
    chk("midrst_tx_valid", o_tx_valid, 0);
    chk("midrst_tx_byte", o_tx_byte, 0);
    chk("midrst_rsp_valid", o_rsp_valid, 0);
    chk("midrst_rsp_data", {o_rsp_err, o_rsp_data}, 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", o_req_ready, 1);
    repeat (30) @(negedge clk);
    chk("midrst_no_rsp", rsp_seen - base_rsp, 0);
    issue(2, 7'h00, 8'h00, 0, 0, 0);

    repeat (10) @(negedge clk);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got cycle %0d, expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
